everloop_engine: RTL and testbench

Self-refreshing serial LED-ring driver: an 8-bit-wide dual-port frame RAM written by the bus side, plus a scanner/serializer that continuously reads `NUM_BYTES` bytes and emits them as a single-wire NRZ pulse stream on `everloop_d`, one bit per `TBIT` cycles. It sits between the Wishbone LED register block and the LED chain pin. The default of 140 bytes is 35 RGBW LEDs × 4 bytes.

---
 rtl/everloop_pkg.sv | 21 ++
 rtl/everloop_dpram.sv | 43 ++++
 rtl/everloop_engine.sv | 162 ++++++++++++++++
 tb/tb_everloop_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/everloop_pkg.sv
// Shared types and default timing for the everloop LED-ring driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package everloop_pkg;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  // Defaults: 35 RGBW LEDs x 4 bytes.
  localparam int DEF_ADR_WIDTH = 11;
  localparam int DEF_NUM_BYTES = 140;
  localparam int DEF_T0H       = 45;
  localparam int DEF_T1H       = 90;
  localparam int DEF_TBIT      = 188;
  localparam int DEF_TRESET    = 12000;

endpackage

// File: rtl/everloop_dpram.sv
// Byte-wide dual-port RAM: write port a, read port b with enable and ack.
// Latency: read data and ack one clk_b cycle after en_b; write lands on the clk_a edge.
// Backpressure: none, both ports accept every cycle; same-address read returns old data.
// Ports: clk_a/we_a/adr_a/dat_a write side; clk_b/rst_b/en_b/adr_b read side -> dat_b/ack_b.
module everloop_dpram #(
  parameter int ADR_WIDTH     = 11,
  parameter     MEM_FILE_NAME = "none"
) (
  input  logic                 clk_a,
  input  logic                 we_a,
  input  logic [ADR_WIDTH-1:0] adr_a,
  input  logic [7:0]           dat_a,
  input  logic                 clk_b,
  input  logic                 rst_b,
  input  logic                 en_b,
  input  logic [ADR_WIDTH-1:0] adr_b,
  output logic [7:0]           dat_b,
  output logic                 ack_b
);

  localparam int DEPTH = 1 << ADR_WIDTH;

  logic [7:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  end

  always_ff @(posedge clk_a) begin
    if (we_a) mem[adr_a] <= dat_a;
  end

  // Separate read process: a same-edge write is not yet visible (read-first).
  always_ff @(posedge clk_b) begin
    if (en_b) dat_b <= mem[adr_b];
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) ack_b <= 1'b0;
    else       ack_b <= en_b;
  end

endmodule

// File: rtl/everloop_engine.sv
// Self-refreshing LED-ring driver: frame RAM scanned and serialised as NRZ pulses on everloop_d.
// Latency: first high TRESET+2 cycles after reset release; frame period TRESET+2+NUM_BYTES*8*TBIT.
// Backpressure: none; bus writes accepted every cycle, the line free-runs.
// Ports: clk, nrst (sync, active-high); wr_en/wr_adr/wr_dat byte writes; everloop_d line, in_gap flag.
module everloop_engine
  import everloop_pkg::*;
#(
  parameter int ADR_WIDTH     = DEF_ADR_WIDTH,
  parameter int NUM_BYTES     = DEF_NUM_BYTES,
  parameter int T0H           = DEF_T0H,
  parameter int T1H           = DEF_T1H,
  parameter int TBIT          = DEF_TBIT,
  parameter int TRESET        = DEF_TRESET,
  parameter     MEM_FILE_NAME = "none"
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 wr_en,
  input  logic [ADR_WIDTH-1:0] wr_adr,
  input  logic [7:0]           wr_dat,
  output logic                 everloop_d,
  output logic                 in_gap
);

  localparam int GW = $clog2(TRESET + 1);
  localparam int PW = $clog2(TBIT);
  localparam logic [GW-1:0]        GAP_LAST = GW'(TRESET - 1);
  localparam logic [PW-1:0]        PH_LAST  = PW'(TBIT - 1);
  localparam logic [PW-1:0]        T0H_C    = PW'(T0H);
  localparam logic [PW-1:0]        T1H_C    = PW'(T1H);
  localparam logic [ADR_WIDTH:0]   NB_C     = (ADR_WIDTH + 1)'(NUM_BYTES);

  state_t               state, state_nxt;
  logic [GW-1:0]        gap_cnt, gap_nxt;
  logic [PW-1:0]        ph, ph_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [ADR_WIDTH:0]   adr, adr_nxt;      // next byte to fetch
  logic                 pf_pend, pend_nxt; // prefetch buffer holds the next byte
  logic [7:0]           shreg, sh_nxt;
  logic [7:0]           pf_buf, pf_nxt;
  logic                 d_nxt;
  logic                 rd_en;
  logic                 rd_ack;
  logic [7:0]           rd_dat;

  everloop_dpram #(
    .ADR_WIDTH     (ADR_WIDTH),
    .MEM_FILE_NAME (MEM_FILE_NAME)
  ) u_ram (
    .clk_a (clk),
    .we_a  (wr_en),
    .adr_a (wr_adr),
    .dat_a (wr_dat),
    .clk_b (clk),
    .rst_b (nrst),
    .en_b  (rd_en),
    .adr_b (adr[ADR_WIDTH-1:0]),
    .dat_b (rd_dat),
    .ack_b (rd_ack)
  );

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    ph_nxt    = ph;
    bit_nxt   = bit_cnt;
    adr_nxt   = adr;
    pend_nxt  = pf_pend;
    sh_nxt    = shreg;
    pf_nxt    = pf_buf;
    d_nxt     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      GAP: begin
        adr_nxt  = '0;
        pend_nxt = 1'b0;
        gap_nxt  = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        adr_nxt   = adr + 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (rd_ack) begin
          sh_nxt    = rd_dat;
          ph_nxt    = '0;
          bit_nxt   = 3'd0;
          d_nxt     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (rd_ack) pf_nxt = rd_dat;
        // Fetch the following byte at the start of bit 7 so it is ready
        // well before the bit ends (TBIT >= 3 leaves room for the ack).
        if (bit_cnt == 3'd7 && ph == '0 && adr < NB_C) begin
          rd_en    = 1'b1;
          adr_nxt  = adr + 1'b1;
          pend_nxt = 1'b1;
        end
        if (ph == PH_LAST) begin
          ph_nxt = '0;
          if (bit_cnt == 3'd7) begin
            if (pf_pend) begin
              sh_nxt   = pf_buf;
              bit_nxt  = 3'd0;
              pend_nxt = 1'b0;
              d_nxt    = 1'b1;
            end else begin
              state_nxt = GAP;
              gap_nxt   = '0;
            end
          end else begin
            sh_nxt  = {shreg[6:0], 1'b0};
            bit_nxt = bit_cnt + 3'd1;
            d_nxt   = 1'b1;
          end
        end else begin
          ph_nxt = ph + 1'b1;
          // Line value for the phase being entered: high for the first
          // T1H/T0H phases of the current bit.
          d_nxt  = (ph_nxt < (shreg[7] ? T1H_C : T0H_C));
        end
      end
      default: state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      ph         <= '0;
      bit_cnt    <= 3'd0;
      adr        <= '0;
      pf_pend    <= 1'b0;
      everloop_d <= 1'b0;
      in_gap     <= 1'b1;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      ph         <= ph_nxt;
      bit_cnt    <= bit_nxt;
      adr        <= adr_nxt;
      pf_pend    <= pend_nxt;
      everloop_d <= d_nxt;
      in_gap     <= (state_nxt == GAP);
    end
  end

  // Data registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    shreg  <= sh_nxt;
    pf_buf <= pf_nxt;
  end

endmodule

// File: tb/tb_everloop_engine.sv
// Self-checking bench for everloop_engine with small timing parameters.
// Expected pulses (width, start cycle) are queued by the stimulus; a negedge monitor
// decodes everloop_d pulses and compares them against the queue.
module tb_everloop_engine;

  localparam int AW     = 4;
  localparam int NB     = 2;
  localparam int T0H    = 2;
  localparam int T1H    = 5;
  localparam int TBIT   = 8;
  localparam int TRESET = 20;

  logic          clk    = 1'b0;
  logic          nrst   = 1'b1;
  logic          wr_en  = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [7:0]    wr_dat = '0;
  logic          everloop_d;
  logic          in_gap;

  everloop_engine #(
    .ADR_WIDTH (AW),
    .NUM_BYTES (NB),
    .T0H       (T0H),
    .T1H       (T1H),
    .TBIT      (TBIT),
    .TRESET    (TRESET)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (wr_en),
    .wr_adr     (wr_adr),
    .wr_dat     (wr_dat),
    .everloop_d (everloop_d),
    .in_gap     (in_gap)
  );

  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  int base   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int width;
    int start;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue the pulses of the first nbits bits of b, bit i starting at start+8*i.
  task automatic push_byte(input logic [7:0] b, input int start, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      exp_t e;
      e.width = b[7-i] ? T1H : T0H;
      e.start = base + start + TBIT * i;
      q.push_back(e);
    end
  endtask

  // Advance to 1 time unit after the edge that begins cycle c.
  task automatic goto(input int c);
    while (gcyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_at(input int c, input logic [AW-1:0] a, input logic [7:0] d);
    goto(c);
    wr_en  = 1'b1;
    wr_adr = a;
    wr_dat = d;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
  endtask

  // Line low for cycles c0..c0+TRESET+1, in_gap high for c0..c0+TRESET-1.
  task automatic scan_gap(input string tag, input int c0);
    int bad_d;
    int bad_g;
    bad_d = 0;
    bad_g = 0;
    for (int c = c0; c < c0 + TRESET + 2; c++) begin
      goto(c);
      if (everloop_d) bad_d++;
      if (c < c0 + TRESET && !in_gap) bad_g++;
    end
    chk({tag, "_line_low_cycles_bad"}, bad_d, 0);
    chk({tag, "_in_gap_cycles_bad"}, bad_g, 0);
  endtask

  // Pulse monitor.
  logic prev = 1'b0;
  int   hi   = 0;
  int   rise = 0;
  always @(negedge clk) begin
    exp_t e;
    if (everloop_d && !prev) begin
      rise = gcyc;
      hi   = 1;
    end else if (everloop_d) begin
      hi++;
    end else if (prev) begin
      chk($sformatf("pulse_expected t=%0d", rise), int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("pulse_start exp_t=%0d", e.start), rise, e.start);
        chk($sformatf("pulse_width t=%0d", e.start), hi, e.width);
      end
    end
    prev = everloop_d;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // RAM loads while held in reset.
    wr_en = 1'b1; wr_adr = 4'd0; wr_dat = 8'hA5;
    @(posedge clk); #1;
    wr_adr = 4'd1; wr_dat = 8'h00;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("reset_line", int'(everloop_d), 0);
    chk("reset_in_gap", int'(in_gap), 1);

    // The last edge applied reset; release now, this is cycle 0.
    nrst = 1'b0;
    base = gcyc;

    push_byte(8'hA5, 22, 8);    // frame 1
    push_byte(8'h00, 86, 8);
    push_byte(8'hFF, 172, 8);   // frame 2: written after frame 1 fetched both bytes
    push_byte(8'h01, 236, 8);
    push_byte(8'hFF, 322, 8);   // frame 3: byte 1 updated live during byte 0
    push_byte(8'h80, 386, 8);
    push_byte(8'h3C, 472, 8);   // frame 4: byte 0 write during frame 3 byte 1
    push_byte(8'h80, 536, 8);   // collision write at the prefetch keeps old 0x80
    push_byte(8'h3C, 622, 8);   // frame 5: collision at FETCH keeps old 0x3C
    push_byte(8'h55, 686, 8);
    push_byte(8'h0F, 772, 4);   // frame 6: reset during first high pulse
    begin
      exp_t e;
      e.width = 3;
      e.start = base + 804;
      q.push_back(e);
    end

    scan_gap("gap1", 0);
    write_at(100, 4'd0, 8'hFF);
    write_at(101, 4'd1, 8'h01);
    goto(149);
    chk("in_gap_while_sending", int'(in_gap), 0);
    scan_gap("gap2", 150);

    write_at(340, 4'd1, 8'h80);
    write_at(400, 4'd0, 8'h3C);
    write_at(528, 4'd1, 8'h55);
    write_at(620, 4'd0, 8'h0F);

    goto(806);
    chk("pre_reset_line_high", int'(everloop_d), 1);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    nrst = 1'b0;
    base = gcyc;
    chk("mid_reset_line", int'(everloop_d), 0);
    chk("mid_reset_in_gap", int'(in_gap), 1);
    push_byte(8'h0F, 22, 8);
    push_byte(8'h55, 86, 8);
    scan_gap("gap3", 0);

    goto(160);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
